fb_port_arbiter: RTL



---
 rtl/fb_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads win, posted host writes drain
// on idle cycles, host reads wait for an empty write FIFO.
module fb_port_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 24,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,

    input  logic                           disp_req,
    input  logic [ADDR_W-1:0]              disp_addr,
    output logic [DATA_W-1:0]              disp_data,
    output logic                           disp_valid,

    input  logic                           host_wr_valid,
    input  logic [ADDR_W-1:0]              host_wr_addr,
    input  logic [DATA_W-1:0]              host_wr_data,
    output logic                           host_wr_ready,

    input  logic                           host_rd_valid,
    input  logic [ADDR_W-1:0]              host_rd_addr,
    output logic                           host_rd_ready,
    output logic [DATA_W-1:0]              host_rd_data,
    output logic                           host_rd_data_valid,

    output logic                           ram_en,
    output logic                           ram_we,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [DATA_W-1:0]              ram_wdata,
    input  logic [DATA_W-1:0]              ram_rdata,

    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(WFIFO_DEPTH);

    logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;

    logic              r_tag_disp;
    logic              r_tag_host;
    logic              r_disp_valid;
    logic              r_host_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] r_host_data;

    logic w_empty;
    logic w_full;
    logic w_gnt_disp;
    logic w_gnt_wr;
    logic w_gnt_hrd;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);

    // Grants are held off while in reset so the RAM port stays quiet.
    assign w_gnt_disp = reset_n && disp_req;
    assign w_gnt_wr   = reset_n && !disp_req && !w_empty;
    assign w_gnt_hrd  = reset_n && !disp_req && w_empty && host_rd_valid;

    assign host_wr_ready = !w_full;
    assign host_rd_ready = reset_n && !disp_req && w_empty;

    assign w_push = host_wr_valid && !w_full;
    assign w_pop  = w_gnt_wr;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (1'b1)
            w_gnt_disp: begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end
            w_gnt_wr: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_fifo_addr[r_rptr];
                ram_wdata = r_fifo_data[r_rptr];
            end
            w_gnt_hrd: begin
                ram_en   = 1'b1;
                ram_addr = host_rd_addr;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // Entry storage needs no reset: pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= host_wr_addr;
            r_fifo_data[r_wptr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_disp   <= 1'b0;
            r_tag_host   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_host_valid <= 1'b0;
            r_disp_data  <= '0;
            r_host_data  <= '0;
        end else begin
            r_tag_disp   <= w_gnt_disp;
            r_tag_host   <= w_gnt_hrd;
            r_disp_valid <= r_tag_disp;
            r_host_valid <= r_tag_host;
            if (r_tag_disp) begin
                r_disp_data <= ram_rdata;
            end
            if (r_tag_host) begin
                r_host_data <= ram_rdata;
            end
        end
    end

    assign disp_data          = r_disp_data;
    assign disp_valid         = r_disp_valid;
    assign host_rd_data       = r_host_data;
    assign host_rd_data_valid = r_host_valid;
    assign wfifo_level        = r_level;

endmodule
